gbsha_fir_top: RTL and testbench

- Top-level wrapper for a small fixed-coefficient transposed-free direct-form FIR filter, packed onto an 8-bit-in / 8-bit-out pin interface.
- Clock, reset and a signed sample share io_in. The filtered, registered, signed result drives io_out.
- Sits at the chip/tile top level. Gate-level builds add power pins vccd1/vssd1, which are not part of the RTL port list.

---
 rtl/gbsha_fir_pkg.sv | 28 ++
 rtl/gbsha_fir_core.sv | 77 +++++++
 rtl/gbsha_fir_top.sv | 34 +++
 tb/tb_gbsha_fir_top.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/gbsha_fir_pkg.sv
// Shared constants for the gbsha FIR: coefficient width, tap limit,
// the fixed coefficient set and the accumulator sizing helper.
package gbsha_fir_pkg;

  localparam int COEF_W   = 4;
  localparam int MAX_TAPS = 8;

  typedef logic signed [COEF_W-1:0] coef_t;

  function automatic coef_t coef(input int k);
    unique case (k)
      0: coef = 4'sd1;
      1: coef = 4'sd2;
      2: coef = 4'sd3;
      3: coef = 4'sd4;
      4: coef = 4'sd4;
      5: coef = 4'sd3;
      6: coef = 4'sd2;
      7: coef = 4'sd1;
      default: coef = 4'sd0;
    endcase
  endfunction

  function automatic int acc_width(input int bw_in, input int n_taps);
    return bw_in + COEF_W + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/gbsha_fir_core.sv
// Direct-form FIR: delay line, MAC, output fit and result register.
// Define FIR_SAT_EN to saturate the result instead of wrapping it.
module gbsha_fir_core
  import gbsha_fir_pkg::*;
#(
  parameter int N_TAPS = 1,
  parameter int BW_in  = 6,
  parameter int BW_out = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [BW_in-1:0]  x_i,
  output logic signed [BW_out-1:0] y_o
);

  localparam int AW = acc_width(BW_in, N_TAPS);

  logic signed [BW_in-1:0]  tap [N_TAPS];
  logic signed [AW-1:0]     acc;
  logic signed [BW_out-1:0] y_d;
  logic signed [BW_out-1:0] y_q;

  assign tap[0] = x_i;

  if (N_TAPS > 1) begin : g_dly
    logic signed [BW_in-1:0] d_q [N_TAPS-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < N_TAPS-1; i++) d_q[i] <= '0;
      end else begin
        d_q[0] <= x_i;
        for (int i = 1; i < N_TAPS-1; i++) d_q[i] <= d_q[i-1];
      end
    end

    for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
      assign tap[k] = d_q[k-1];
    end
  end

  // Operands widened to the full accumulator width so no term overflows
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++)
      acc = acc + AW'(tap[k]) * AW'(coef(k));
  end

  if (AW > BW_out) begin : g_fit
`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] YMAX =
      {{(AW-BW_out+1){1'b0}}, {(BW_out-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN =
      {{(AW-BW_out+1){1'b1}}, {(BW_out-1){1'b0}}};

    always_comb begin
      y_d = acc[BW_out-1:0];
      if (acc > YMAX)
        y_d = {1'b0, {(BW_out-1){1'b1}}};
      else if (acc < YMIN)
        y_d = {1'b1, {(BW_out-1){1'b0}}};
    end
`else
    assign y_d = acc[BW_out-1:0];
`endif
  end else begin : g_ext
    assign y_d = BW_out'(acc);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) y_q <= '0;
    else       y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/gbsha_fir_top.sv
// Pin wrapper: clk/rst/sample unpacked from io_in, result on io_out.
// Build with FIR_SAT_EN defined for a saturating output stage.
module gbsha_fir_top
  import gbsha_fir_pkg::*;
#(
  parameter int N_TAPS = 1,
  parameter int BW_in  = 6,
  parameter int BW_out = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic signed [BW_in-1:0]  x;
  logic signed [BW_out-1:0] y;
  logic                     unused_io;

  assign x         = io_in[BW_in+1:2];
  assign unused_io = ^io_in;

  gbsha_fir_core #(
    .N_TAPS (N_TAPS),
    .BW_in  (BW_in),
    .BW_out (BW_out)
  ) u_core (
    .clk_i (io_in[0]),
    .rst_i (io_in[1]),
    .x_i   (x),
    .y_o   (y)
  );

  assign io_out = 8'($unsigned(y));

endmodule

// File: tb/tb_gbsha_fir_top.sv
// Self-checking bench: three FIR configurations against an arithmetic
// reference model, plus literal expectations for directed sequences.
module tb_gbsha_fir_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] xin = 6'd0;
  logic [7:0] io_in;
  logic [7:0] out1, out4, out8;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  int H [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int hist [8];
  logic [7:0] e1, e4, e8;

  assign io_in = {xin, rst, clk};

  always #5 clk = ~clk;

  gbsha_fir_top dut1 (.io_in(io_in), .io_out(out1));

  gbsha_fir_top #(.N_TAPS(4)) dut4 (.io_in(io_in), .io_out(out4));

  gbsha_fir_top #(.N_TAPS(8), .BW_in(4), .BW_out(6)) dut8 (
    .io_in(io_in), .io_out(out8)
  );

  function automatic logic [7:0] fir(int n, int bwi, int bwo);
    int acc, xv, v, full, half;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      xv = hist[k] & ((1 << bwi) - 1);
      if (xv >= (1 << (bwi - 1))) xv -= (1 << bwi);
      acc += H[k] * xv;
    end
    full = 1 << bwo;
    half = 1 << (bwo - 1);
`ifdef FIR_SAT_EN
    if (acc > half - 1)   v = half - 1;
    else if (acc < -half) v = -half;
    else                  v = acc;
`else
    v = acc & (full - 1);
    if (v >= half) v -= full;
`endif
    return 8'(v & (full - 1));
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one sample/reset for one edge and advance the model.
  task automatic cyc(input int xv, input bit r);
    @(negedge clk);
    xin = 6'(xv);
    rst = r;
    if (r) begin
      for (int k = 0; k < 8; k++) hist[k] = 0;
    end else begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = xv & 63;
    end
    e1 = fir(1, 6, 8);
    e4 = fir(4, 6, 8);
    e8 = fir(8, 4, 6);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      chk("model_n1", out1, e1);
      chk("model_n4", out4, e4);
      chk("model_n8", out8, e8);
    end
  end

  task automatic lit4(string name, int xv, int yv);
    cyc(xv, 1'b0);
    chk(name, out4, 8'(yv));
  endtask

  initial begin
    int sat31 [4];
    int sat32 [4];
`ifdef FIR_SAT_EN
    sat31 = '{31, 93, 127, 127};
    sat32 = '{-32, -96, -128, -128};
`else
    sat31 = '{31, 93, -70, 54};
    sat32 = '{-32, -96, 64, -64};
`endif
    for (int k = 0; k < 8; k++) hist[k] = 0;

    cyc(31, 1'b1);
    cyc(31, 1'b1);
    chk("reset_n1", out1, 8'h00);
    chk("reset_n4", out4, 8'h00);
    cyc(0, 1'b0);
    chk("post_reset_zero", out1, 8'h00);

    cyc(-5, 1'b0);
    chk("x_m5", out1, 8'hFB);
    cyc(31, 1'b0);
    chk("x_31", out1, 8'h1F);
    cyc(-32, 1'b0);
    chk("x_m32", out1, 8'hE0);

    cyc(0, 1'b1);
    lit4("imp0", 1, 1);
    lit4("imp1", 0, 2);
    lit4("imp2", 0, 3);
    lit4("imp3", 0, 4);
    lit4("imp4", 0, 0);
    lit4("imp5", 0, 0);

    cyc(0, 1'b1);
    for (int i = 0; i < 4; i++) lit4($sformatf("hold31_%0d", i), 31, sat31[i]);
    cyc(0, 1'b1);
    for (int i = 0; i < 4; i++) lit4($sformatf("holdm32_%0d", i), -32, sat32[i]);

    cyc(0, 1'b1);
    lit4("mid0", 1, 1);
    lit4("mid1", 1, 3);
    cyc(1, 1'b1);
    chk("mid_rst", out4, 8'h00);
    lit4("mid2", 1, 1);
    lit4("mid3", 1, 3);
    lit4("mid4", 1, 6);
    lit4("mid5", 1, 10);

    for (int i = 0; i < 400; i++)
      cyc(int'($urandom_range(0, 63)), ($urandom_range(0, 19) == 0));

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
